ikaopll_buswriter: RTL
======================

IKAOPLL_BUSWRITER -- requirements
Module: ikaopll_buswriter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The clock port SHALL be i_EMUCLK and the reset port SHALL be i_IC_n.
REQ-002 Parameter WR_PULSE, default 2, SHALL set the CS_n/WR_n low width in ticks; legal range 1..255.
REQ-003 Parameter ADDR_WAIT, default 12, SHALL set the ticks from address WR_n rise to data setup; legal range 2..255.
REQ-004 Parameter DATA_WAIT, default 84, SHALL set the ticks from data WR_n rise to completion; legal range 2..255.
REQ-005 i_EMUCLK  in  1  master clock (XIN rate).
REQ-006 i_IC_n  in  1  asynchronous active-low reset.
REQ-007 i_phiM_PCEN_n  in  1  tick enable, active-low; a tick is an i_EMUCLK rising edge with this input at 0.
REQ-008 i_VALID  in  1  write request.
REQ-009 i_ADDR  in  8  OPLL register address.
REQ-010 i_DATA  in  8  OPLL register data.
REQ-011 o_READY  out  1  block can accept a request.
REQ-012 o_DONE  out  1  one-clock completion pulse.
REQ-013 o_CS_n, o_WR_n, o_A0  out  1 each  OPLL bus control.
REQ-014 o_D  out  8  OPLL bus data.
REQ-015 o_D_OE  out  1  data driver enable.

Function
REQ-016 A request SHALL be accepted on any i_EMUCLK edge with i_VALID=1 and o_READY=1, irrespective of tick. i_ADDR and i_DATA SHALL be latched at that edge, and later changes SHALL be ignored.
REQ-017 The state machine SHALL have the states IDLE, A_SETUP, A_STB, A_HOLD, A_WAIT, D_SETUP, D_STB, D_HOLD and D_WAIT.
REQ-018 The transition IDLE->A_SETUP SHALL occur on the accept edge. Every other transition SHALL occur only on ticks.
REQ-019 SETUP SHALL last 1 tick, STB WR_PULSE ticks, HOLD 1 tick, A_WAIT ADDR_WAIT-1 ticks and D_WAIT DATA_WAIT-1 ticks. The count SHALL use an 8-bit down-counter loaded on state entry.
REQ-020 Transitions: A_WAIT->D_SETUP; D_WAIT->IDLE.
REQ-021 o_CS_n and o_WR_n SHALL be 0 only in A_STB/D_STB and 1 otherwise; CS_n and WR_n SHALL switch on the same edge.
REQ-022 o_A0 SHALL be 0 in the A_* states and 1 in the D_* states. o_A0 SHALL hold its last value in IDLE; its reset value SHALL be 0.
REQ-023 In SETUP, STB and HOLD, o_D SHALL be the latched address (A_*) or the latched data (D_*), and o_D_OE SHALL be 1. In all other states o_D_OE SHALL be 0 and o_D SHALL be 0x00.
REQ-024 o_READY SHALL be 1 only in IDLE. A request presented while o_READY=0 SHALL be neither accepted nor queued.
REQ-025 o_DONE SHALL be 1 for exactly one clock, on the clock following the D_WAIT->IDLE edge; o_READY SHALL already be 1 during that clock.
REQ-026 A request accept SHALL be possible during the o_DONE clock.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-028 Latency with the tick input held at 0 SHALL be (1+WR_PULSE+ADDR_WAIT)+(1+WR_PULSE+DATA_WAIT) clocks from the accept edge to the edge returning to IDLE.
REQ-029 Ticks may arrive at any spacing and with gaps. When no tick occurs, state, counter and outputs SHALL hold.

Reset
REQ-030 While i_IC_n=0, outputs SHALL immediately be: o_CS_n=1, o_WR_n=1, o_A0=0, o_D=0x00, o_D_OE=0, o_READY=0, o_DONE=0. The state SHALL be IDLE and the counter 0.
REQ-031 o_READY SHALL rise on the first clock edge after i_IC_n deasserts.
REQ-032 Reset during any state, including mid-strobe, SHALL abort the transfer with no o_DONE.

Verification
REQ-033 Defaults, tick input tied 0; write 0x10/0x55:
- o_D=0x10 with A0=0 and CS_n/WR_n low for cycles 2-3 after accept.
- o_D=0x55 with A0=1 and CS_n/WR_n low for cycles 17-18.
- o_DONE high in cycle 103; total 102 clocks.
REQ-034 Tick every 4th clock (3 high, 1 low); write 0x30/0x0F:
- each strobe low for 8 clocks;
- WR_n rise to address setup of data phase = 48 clocks;
- data WR_n rise to IDLE = 336 clocks.
REQ-035 i_VALID held high with changing i_ADDR during a transfer:
- no second accept until o_READY=1;
- bus shows only the values latched at accept;
- back-to-back accepts spaced 103 clocks.
REQ-036 Assert i_IC_n=0 during A_STB:
- CS_n/WR_n return to 1 and o_D_OE to 0 with no clock edge;
- no o_DONE;
- after release, o_READY=1 one edge later and the next write completes normally.
REQ-037 Parameters WR_PULSE=1, ADDR_WAIT=2, DATA_WAIT=2 with tick input tied 0: the total transaction SHALL take 8 clocks, with o_DONE pulsed once.

Source files
------------

// File: rtl/ikaopll_buswriter_if.sv
// Request/completion handshake plus the OPLL CPU-bus pins driven by ikaopll_buswriter.
// The master side issues register writes; the slave side is the bus writer itself.
interface ikaopll_buswriter_if;
   logic       i_VALID;
   logic [7:0] i_ADDR;
   logic [7:0] i_DATA;
   logic       o_READY;
   logic       o_DONE;
   logic       o_CS_n;
   logic       o_WR_n;
   logic       o_A0;
   logic [7:0] o_D;
   logic       o_D_OE;

   modport master (
      output i_VALID, i_ADDR, i_DATA,
      input  o_READY, o_DONE, o_CS_n, o_WR_n, o_A0, o_D, o_D_OE
   );

   modport slave (
      input  i_VALID, i_ADDR, i_DATA,
      output o_READY, o_DONE, o_CS_n, o_WR_n, o_A0, o_D, o_D_OE
   );
endinterface

// File: rtl/ikaopll_buswriter.sv
// Turns one (address, data) request into a two-phase OPLL CPU-bus write, with
// phase timing counted in phiM ticks and every output registered.
module ikaopll_buswriter #(
   parameter int unsigned WR_PULSE  = 2,
   parameter int unsigned ADDR_WAIT = 12,
   parameter int unsigned DATA_WAIT = 84
) (
   input  logic                  i_EMUCLK,
   input  logic                  i_IC_n,
   input  logic                  i_phiM_PCEN_n,
   ikaopll_buswriter_if.slave    bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      A_SETUP = 4'd1,
      A_STB   = 4'd2,
      A_HOLD  = 4'd3,
      A_WAIT  = 4'd4,
      D_SETUP = 4'd5,
      D_STB   = 4'd6,
      D_HOLD  = 4'd7,
      D_WAIT  = 4'd8
   } state_t;

   // Counter reload values: a state lasts (load + 1) ticks.
   localparam logic [7:0] STB_LOAD   = 8'(WR_PULSE - 32'd1);
   localparam logic [7:0] AWAIT_LOAD = 8'(ADDR_WAIT - 32'd2);
   localparam logic [7:0] DWAIT_LOAD = 8'(DATA_WAIT - 32'd2);

   function automatic state_t next_phase(input state_t st);
      case (st)
         A_SETUP: next_phase = A_STB;
         A_STB:   next_phase = A_HOLD;
         A_HOLD:  next_phase = A_WAIT;
         A_WAIT:  next_phase = D_SETUP;
         D_SETUP: next_phase = D_STB;
         D_STB:   next_phase = D_HOLD;
         D_HOLD:  next_phase = D_WAIT;
         D_WAIT:  next_phase = IDLE;
         default: next_phase = IDLE;
      endcase
   endfunction

   function automatic logic [7:0] entry_count(input state_t st);
      case (st)
         A_STB, D_STB: entry_count = STB_LOAD;
         A_WAIT:       entry_count = AWAIT_LOAD;
         D_WAIT:       entry_count = DWAIT_LOAD;
         default:      entry_count = 8'd0;
      endcase
   endfunction

   state_t     state_r;
   state_t     state_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_s;
   logic [7:0] addr_r;
   logic [7:0] addr_s;
   logic [7:0] data_r;
   logic [7:0] data_s;
   logic       tick_s;
   logic       accept_s;

   logic       cs_n_r;
   logic       wr_n_r;
   logic       a0_r;
   logic [7:0] d_r;
   logic       d_oe_r;
   logic       ready_r;
   logic       done_r;

   logic       strobe_s;
   logic       a0_s;
   logic [7:0] d_s;
   logic       d_oe_s;
   logic       ready_s;
   logic       done_s;

   assign tick_s   = ~i_phiM_PCEN_n;
   // Acceptance ignores ticks; ready_r is only ever set while the FSM sits in IDLE.
   assign accept_s = bus.i_VALID & ready_r & (state_r == IDLE);

   // Next-state, tick counter and request latch.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      addr_s  = addr_r;
      data_s  = data_r;
      if (accept_s) begin
         addr_s = bus.i_ADDR;
         data_s = bus.i_DATA;
      end else begin
         addr_s = addr_r;
         data_s = data_r;
      end
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = A_SETUP;
               cnt_s   = 8'd0;
            end else begin
               state_s = IDLE;
               cnt_s   = 8'd0;
            end
         end
         A_SETUP, A_STB, A_HOLD, A_WAIT, D_SETUP, D_STB, D_HOLD, D_WAIT: begin
            if (tick_s) begin
               if (cnt_r == 8'd0) begin
                  state_s = next_phase(state_r);
                  cnt_s   = entry_count(next_phase(state_r));
               end else begin
                  state_s = state_r;
                  cnt_s   = cnt_r - 8'd1;
               end
            end else begin
               state_s = state_r;
               cnt_s   = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // Output values for the state being entered, so the registered pins track the state without lag.
   always_comb begin
      strobe_s = (state_s == A_STB) || (state_s == D_STB);
      a0_s     = a0_r;
      d_s      = 8'h00;
      d_oe_s   = 1'b0;
      case (state_s)
         A_SETUP, A_STB, A_HOLD: begin
            a0_s   = 1'b0;
            d_s    = addr_s;
            d_oe_s = 1'b1;
         end
         A_WAIT: begin
            a0_s = 1'b0;
         end
         D_SETUP, D_STB, D_HOLD: begin
            a0_s   = 1'b1;
            d_s    = data_s;
            d_oe_s = 1'b1;
         end
         D_WAIT: begin
            a0_s = 1'b1;
         end
         default: begin
            a0_s = a0_r;
         end
      endcase
      ready_s = (state_s == IDLE);
      done_s  = (state_r == D_WAIT) && (state_s == IDLE);
   end

   // State, counter and latched request registers.
   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
         addr_r  <= 8'h00;
         data_r  <= 8'h00;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         addr_r  <= addr_s;
         data_r  <= data_s;
      end
   end

   // Registered bus and handshake outputs; reset clears them asynchronously, aborting any strobe.
   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         cs_n_r  <= 1'b1;
         wr_n_r  <= 1'b1;
         a0_r    <= 1'b0;
         d_r     <= 8'h00;
         d_oe_r  <= 1'b0;
         ready_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         cs_n_r  <= ~strobe_s;
         wr_n_r  <= ~strobe_s;
         a0_r    <= a0_s;
         d_r     <= d_s;
         d_oe_r  <= d_oe_s;
         ready_r <= ready_s;
         done_r  <= done_s;
      end
   end

   assign bus.o_CS_n  = cs_n_r;
   assign bus.o_WR_n  = wr_n_r;
   assign bus.o_A0    = a0_r;
   assign bus.o_D     = d_r;
   assign bus.o_D_OE  = d_oe_r;
   assign bus.o_READY = ready_r;
   assign bus.o_DONE  = done_r;

endmodule
